// File: rtl/apb_reg_bank_pkg.sv
// Shared types and constants for the APB configuration register bank.
// Register indices, STATUS/CTRL bit positions and address decode geometry.
package apb_reg_bank_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int IDX_CTRL     = 0;
  localparam int IDX_DATA_IN  = 1;
  localparam int IDX_CW_WIDTH = 2;
  localparam int IDX_NOISE    = 3;

  localparam int ST_DONE = 0;
  localparam int ST_BUSY = 1;

  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;

  localparam int ADDR_LSB = 2;
  localparam int IDX_W    = 4;

endpackage

// File: rtl/apb_reg_bank_access_ctrl.sv
// APB transfer sequencer: paces wait states and raises a single-cycle commit
// strobe, followed by a registered one-cycle PREADY.
module apb_access_ctrl
  import apb_reg_bank_pkg::*;
#(
  parameter int WAIT_STATES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic psel,
  input  logic penable,
  output logic commit_o,
  output logic pready_o
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       pready_q, pready_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pready_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pready_q <= pready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (psel && penable) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        // A master dropping PSEL mid-transfer abandons it without a commit.
        if (!psel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == WS) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    commit_o = (state_q == WAIT) && psel && (cnt_q == WS);
    pready_d = commit_o;
  end

  assign pready_o = pready_q;

endmodule

// File: rtl/apb_reg_bank.sv
// APB slave register bank for the codec: RW configuration registers, a
// read-only STATUS word, start pulse generation and a sticky done interrupt.
module apb_reg_bank
  import apb_reg_bank_pkg::*;
#(
  parameter int AMBA_ADDR_WIDTH = 32,
  parameter int AMBA_WORD       = 32,
  parameter int NUM_REGS        = 4,
  parameter int WAIT_STATES     = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [AMBA_ADDR_WIDTH-1:0]    PADDR,
  input  logic [AMBA_WORD-1:0]          PWDATA,
  input  logic [AMBA_WORD/8-1:0]        PSTRB,
  input  logic                          PSEL,
  input  logic                          PENABLE,
  input  logic                          PWRITE,
  output logic [AMBA_WORD-1:0]          PRDATA,
  output logic                          PREADY,
  output logic                          PSLVERR,
  output logic [NUM_REGS*AMBA_WORD-1:0] regs_o,
  output logic                          start_o,
  input  logic                          core_busy_i,
  input  logic                          core_done_i,
  output logic                          irq_o
);

  localparam int             NB         = AMBA_WORD / 8;
  localparam logic [IDX_W-1:0] STATUS_IDX = IDX_W'(NUM_REGS);

  logic [AMBA_WORD-1:0] regs_q [NUM_REGS];
  logic [AMBA_WORD-1:0] regs_d [NUM_REGS];
  logic [AMBA_WORD-1:0] prdata_q, prdata_d, rd_word;
  logic                 pslverr_q, pslverr_d;
  logic                 start_q, start_d;
  logic                 done_q, done_d;
  logic                 irq_q, irq_d;
  logic                 commit;
  logic [IDX_W-1:0]     idx;
  logic                 addr_ok, is_rw, is_status, wr_ok;
  logic                 unused_addr;

  apb_access_ctrl #(
    .WAIT_STATES(WAIT_STATES)
  ) u_access_ctrl (
    .clk      (clk),
    .rst      (rst),
    .psel     (PSEL),
    .penable  (PENABLE),
    .commit_o (commit),
    .pready_o (PREADY)
  );

  // Address bits above the index field are not decoded.
  assign unused_addr = ^PADDR[AMBA_ADDR_WIDTH-1:ADDR_LSB+IDX_W];

  assign idx       = PADDR[ADDR_LSB +: IDX_W];
  assign addr_ok   = (PADDR[1:0] == 2'b00);
  assign is_rw     = addr_ok && (idx < STATUS_IDX);
  assign is_status = addr_ok && (idx == STATUS_IDX);
  assign wr_ok     = commit && PWRITE && is_rw && !core_busy_i;

  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_ok && (idx == IDX_W'(i)) && PSTRB[b]) begin
          regs_d[i][b*8 +: 8] = PWDATA[b*8 +: 8];
        end
      end
    end
  end

  always_comb begin
    rd_word = '0;
    if (is_rw) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (idx == IDX_W'(i)) rd_word = regs_q[i];
      end
    end else if (is_status) begin
      rd_word[ST_BUSY] = core_busy_i;
      rd_word[ST_DONE] = done_q;
    end
  end

  always_comb begin
    prdata_d  = prdata_q;
    pslverr_d = 1'b0;
    start_d   = 1'b0;
    if (commit) begin
      if (PWRITE) begin
        pslverr_d = !(is_rw && !core_busy_i);
        start_d   = wr_ok && (idx == IDX_W'(IDX_CTRL)) && PSTRB[0] && PWDATA[CTRL_START];
      end else begin
        prdata_d  = rd_word;
        pslverr_d = !(is_rw || is_status);
      end
    end
    // A done pulse in the same cycle as the clearing STATUS read keeps the flag.
    done_d = core_done_i || (done_q && !(commit && !PWRITE && is_status));
    irq_d  = done_q && regs_q[IDX_CTRL][CTRL_IRQ_EN];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
      start_q   <= start_d;
      done_q    <= done_d;
      irq_q     <= irq_d;
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs_out
    assign regs_o[gi*AMBA_WORD +: AMBA_WORD] = regs_q[gi];
  end

  assign PRDATA  = prdata_q;
  assign PSLVERR = pslverr_q;
  assign start_o = start_q;
  assign irq_o   = irq_q;

endmodule

// File: tb/tb_apb_reg_bank.sv
// Directed bench for apb_reg_bank: vector table for single accesses plus
// hand sequences for start, interrupt, coincident done/clear and reset abort.
module tb_apb_reg_bank;

  localparam int WS  = 2;
  localparam int NR  = 4;
  localparam int LAT = WS + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [31:0]   PADDR = '0;
  logic [31:0]   PWDATA = '0;
  logic [3:0]    PSTRB = '0;
  logic          PSEL = 1'b0;
  logic          PENABLE = 1'b0;
  logic          PWRITE = 1'b0;
  logic [31:0]   PRDATA;
  logic          PREADY;
  logic          PSLVERR;
  logic [NR*32-1:0] regs_o;
  logic          start_o;
  logic          core_busy_i = 1'b0;
  logic          core_done_i = 1'b0;
  logic          irq_o;

  int n_checks = 0;
  int n_fail   = 0;

  apb_reg_bank #(
    .AMBA_ADDR_WIDTH(32),
    .AMBA_WORD      (32),
    .NUM_REGS       (NR),
    .WAIT_STATES    (WS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .PADDR       (PADDR),
    .PWDATA      (PWDATA),
    .PSTRB       (PSTRB),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PWRITE      (PWRITE),
    .PRDATA      (PRDATA),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR),
    .regs_o      (regs_o),
    .start_o     (start_o),
    .core_busy_i (core_busy_i),
    .core_done_i (core_done_i),
    .irq_o       (irq_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic        wr;
    logic        busy;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apb(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb,
                     input logic wr, input logic busy, input logic pulse_done,
                     output logic [31:0] rdata, output logic err, output int lat,
                     output logic st);
    @(posedge clk); #1;
    PADDR = addr; PWDATA = wdata; PSTRB = strb; PWRITE = wr; PSEL = 1'b1; PENABLE = 1'b0;
    core_busy_i = busy;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    lat = 0; rdata = 'x; err = 1'bx; st = 1'bx;
    forever begin
      @(posedge clk); #1;
      lat++;
      core_done_i = pulse_done && (lat == WS + 1);
      if (PREADY) begin
        rdata = PRDATA; err = PSLVERR; st = start_o;
        break;
      end
      if (lat > 40) begin
        n_checks++; n_fail++;
        $display("FAIL timeout: PREADY got 0 expected 1 within 40 cycles");
        break;
      end
    end
    PSEL = 1'b0; PENABLE = 1'b0; core_done_i = 1'b0; core_busy_i = 1'b0;
    $display("xfer %s addr=%h wdata=%h strb=%b busy=%0d -> rdata=%h err=%0d lat=%0d start=%0d",
             wr ? "WR" : "RD", addr, wdata, strb, busy, rdata, err, lat, st);
  endtask

  logic [31:0] rd;
  logic        er, st;
  int          lt;

  initial begin
    vecs[0]  = '{32'h4,  32'hA5A5_0003, 4'hF, 1'b1, 1'b0, 32'h0,         1'b0};
    vecs[1]  = '{32'h4,  32'h0,         4'hF, 1'b0, 1'b0, 32'hA5A5_0003, 1'b0};
    vecs[2]  = '{32'h8,  32'h1234_5678, 4'hF, 1'b1, 1'b0, 32'h0,         1'b0};
    vecs[3]  = '{32'h8,  32'hFFFF_FFFF, 4'h2, 1'b1, 1'b0, 32'h0,         1'b0};
    vecs[4]  = '{32'h8,  32'h0,         4'hF, 1'b0, 1'b0, 32'h1234_FF78, 1'b0};
    vecs[5]  = '{32'hC,  32'h0000_0010, 4'hF, 1'b1, 1'b0, 32'h0,         1'b0};
    vecs[6]  = '{32'hC,  32'h0,         4'hF, 1'b0, 1'b0, 32'h0000_0010, 1'b0};
    vecs[7]  = '{32'h14, 32'h0,         4'hF, 1'b0, 1'b0, 32'h0,         1'b1};
    vecs[8]  = '{32'h2,  32'h0,         4'hF, 1'b0, 1'b0, 32'h0,         1'b1};
    vecs[9]  = '{32'h10, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b0, 32'h0,         1'b1};
    vecs[10] = '{32'h10, 32'h0,         4'hF, 1'b0, 1'b0, 32'h0,         1'b0};
    vecs[11] = '{32'h0,  32'h0000_0002, 4'hF, 1'b1, 1'b1, 32'h0,         1'b1};
    vecs[12] = '{32'h0,  32'h0,         4'hF, 1'b0, 1'b0, 32'h0,         1'b0};
    vecs[13] = '{32'h10, 32'h0,         4'hF, 1'b0, 1'b1, 32'h2,         1'b0};

    // Reset state
    #12;
    chk("rst_pready",  {31'b0, PREADY},  32'h0);
    chk("rst_pslverr", {31'b0, PSLVERR}, 32'h0);
    chk("rst_prdata",  PRDATA,           32'h0);
    chk("rst_regs",    regs_o[31:0] | regs_o[63:32] | regs_o[95:64] | regs_o[127:96], 32'h0);
    chk("rst_start_irq", {30'b0, start_o, irq_o}, 32'h0);
    @(posedge clk); #1 rst = 1'b1;

    for (int i = 0; i < 14; i++) begin
      apb(vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].wr, vecs[i].busy, 1'b0, rd, er, lt, st);
      chk($sformatf("v%0d_lat", i), 32'(lt), 32'(LAT));
      chk($sformatf("v%0d_err", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
      if (!vecs[i].wr) chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
    end
    chk("tbl_reg0", regs_o[31:0],   32'h0);
    chk("tbl_reg1", regs_o[63:32],  32'hA5A5_0003);
    chk("tbl_reg2", regs_o[95:64],  32'h1234_FF78);
    chk("tbl_reg3", regs_o[127:96], 32'h0000_0010);
    repeat (3) @(posedge clk);
    #1 chk("prdata_hold", PRDATA, 32'h2);

    // Start pulse, then blocked by busy
    apb(32'h0, 32'h1, 4'hF, 1'b1, 1'b0, 1'b0, rd, er, lt, st);
    chk("start_at_pready", {31'b0, st}, 32'h1);
    chk("start_err", {31'b0, er}, 32'h0);
    @(posedge clk); #1 chk("start_one_cycle", {31'b0, start_o}, 32'h0);
    chk("ctrl_after_start", regs_o[31:0], 32'h1);
    apb(32'h0, 32'h3, 4'hF, 1'b1, 1'b1, 1'b0, rd, er, lt, st);
    chk("busy_err", {31'b0, er}, 32'h1);
    chk("busy_no_start", {31'b0, st}, 32'h0);
    chk("busy_ctrl_kept", regs_o[31:0], 32'h1);

    // Interrupt via sticky done
    apb(32'h0, 32'h2, 4'hF, 1'b1, 1'b0, 1'b0, rd, er, lt, st);
    chk("irqen_no_start", {31'b0, st}, 32'h0);
    chk("irq_idle", {31'b0, irq_o}, 32'h0);
    @(posedge clk); #1 core_done_i = 1'b1;
    @(posedge clk); #1 core_done_i = 1'b0;
    @(posedge clk); #1 chk("irq_set", {31'b0, irq_o}, 32'h1);
    apb(32'h10, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0, rd, er, lt, st);
    chk("status_done", rd, 32'h1);
    repeat (2) @(posedge clk);
    #1 chk("irq_cleared", {31'b0, irq_o}, 32'h0);
    apb(32'h10, 32'h0, 4'hF, 1'b0, 1'b0, 1'b1, rd, er, lt, st);
    chk("status_coincident", rd, 32'h0);
    repeat (2) @(posedge clk);
    #1 chk("irq_set_wins", {31'b0, irq_o}, 32'h1);
    apb(32'h10, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0, rd, er, lt, st);
    chk("status_after_coinc", rd, 32'h1);

    // Reset during WAIT of a write
    @(posedge clk); #1;
    PADDR = 32'h4; PWDATA = 32'hDEAD_BEEF; PSTRB = 4'hF; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
    @(posedge clk); #1 PENABLE = 1'b1;
    @(posedge clk); @(posedge clk); #2 rst = 1'b0;
    #1;
    chk("abort_pready",  {31'b0, PREADY},  32'h0);
    chk("abort_pslverr", {31'b0, PSLVERR}, 32'h0);
    chk("abort_prdata",  PRDATA,           32'h0);
    chk("abort_start_irq", {30'b0, start_o, irq_o}, 32'h0);
    chk("abort_regs", regs_o[31:0] | regs_o[63:32] | regs_o[95:64] | regs_o[127:96], 32'h0);
    @(posedge clk); #1 PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 chk("abort_no_write", regs_o[63:32], 32'h0);
    apb(32'h4, 32'h0000_0055, 4'hF, 1'b1, 1'b0, 1'b0, rd, er, lt, st);
    chk("post_rst_lat", 32'(lt), 32'(LAT));
    chk("post_rst_err", {31'b0, er}, 32'h0);
    apb(32'h4, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0, rd, er, lt, st);
    chk("post_rst_read", rd, 32'h0000_0055);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
